// File: rtl/ixc_uclk_div_gate.sv
// ixc_uclk_div_gate
// Divides the free-running emulator user clock (uclk) by an integer N to
// produce a gated design clock. The block emits a one-cycle enable pulse at
// each derived rising edge and a derived clock level. A start/stop
// request/acknowledge handshake turns generation on and off.
// A stop always waits for the current period to finish, so no truncated
// (glitch) period is ever produced. Every output is registered.

module ixc_uclk_div_gate #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             uclk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             start_req,
  output logic             start_ack,
  input  logic             stop_req,
  output logic             stop_ack,
  output logic             clk_en,
  output logic             clk_lvl,
  output logic             running,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             ratio_err
);

  // IDLE  : nothing generated, waiting for a start request
  // RUN   : generating periods, one enable pulse per period
  // DRAIN : a stop is pending; finish the current period without new edges
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // The smallest legal period. Anything shorter would leave no low phase.
  localparam logic [DIV_W-1:0] MIN_RATIO = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  state_e           state_q,     state_d;
  logic [DIV_W-1:0] phase_q,     phase_d;
  logic [DIV_W-1:0] nlat_q,      nlat_d;
  logic             startAck_q,  startAck_d;
  logic             stopAck_q,   stopAck_d;
  logic             clkEn_q,     clkEn_d;
  logic             clkLvl_q,    clkLvl_d;
  logic             running_q,   running_d;
  logic [CNT_W-1:0] edgeCnt_q,   edgeCnt_d;
  logic             ratioErr_q,  ratioErr_d;

  logic             ratioIllegal;
  logic [DIV_W-1:0] ratioLoad;
  logic             lastPhase;
  logic [DIV_W-1:0] phaseInc;

  // High for the first ceil(n/2) cycles of a period. An odd period therefore
  // gives its extra cycle to the high phase. The sum is widened by one bit so
  // that the largest ratio does not overflow.
  function automatic logic levelFor(input logic [DIV_W-1:0] ph,
                                    input logic [DIV_W-1:0] n);
    logic [DIV_W:0] halfUp;
    halfUp = ({1'b0, n} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
    return ({1'b0, ph} < halfUp);
  endfunction

  // An illegal ratio is replaced by the minimum period. The caller records
  // the fact in the sticky error flag.
  assign ratioIllegal = (div_ratio < MIN_RATIO);
  assign ratioLoad    = ratioIllegal ? MIN_RATIO : div_ratio;
  assign lastPhase    = (phase_q == (nlat_q - ONE));
  assign phaseInc     = phase_q + ONE;

  // Next-state and next-output decode. The outputs are computed for the cycle
  // being entered, so that registering them gives the visible behaviour
  // directly.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    nlat_d     = nlat_q;
    ratioErr_d = ratioErr_q;
    startAck_d = 1'b0;
    stopAck_d  = 1'b0;
    clkEn_d    = 1'b0;
    clkLvl_d   = 1'b0;
    running_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A start wins over a simultaneous stop. The first derived edge
        // appears in the same cycle as the acknowledge.
        if (start_req) begin
          state_d    = RUN;
          phase_d    = '0;
          nlat_d     = ratioLoad;
          ratioErr_d = ratioErr_q | ratioIllegal;
          startAck_d = 1'b1;
          running_d  = 1'b1;
          clkEn_d    = 1'b1;
          clkLvl_d   = 1'b1;
        end
      end

      RUN: begin
        if (stop_req && lastPhase) begin
          // The period ends this cycle anyway. Go straight to IDLE and
          // suppress the edge the wrap would have produced.
          state_d   = IDLE;
          phase_d   = '0;
          stopAck_d = 1'b1;
        end else begin
          running_d = 1'b1;
          if (lastPhase) begin
            // At a period boundary a new ratio is picked up, so a mid-period
            // change of div_ratio only takes effect from here on.
            phase_d    = '0;
            nlat_d     = ratioLoad;
            ratioErr_d = ratioErr_q | ratioIllegal;
            clkEn_d    = 1'b1;
          end else begin
            phase_d = phaseInc;
            if (stop_req) begin
              state_d = DRAIN;
            end
          end
          clkLvl_d = levelFor(phase_d, nlat_d);
        end
      end

      DRAIN: begin
        if (lastPhase) begin
          state_d   = IDLE;
          phase_d   = '0;
          stopAck_d = 1'b1;
        end else begin
          phase_d   = phaseInc;
          running_d = 1'b1;
          clkLvl_d  = levelFor(phase_d, nlat_q);
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    edgeCnt_d = edgeCnt_q + CNT_W'(clkEn_d);
  end

  // State and registered outputs. The reset is synchronous and aborts any run
  // or drain without an acknowledge.
  always_ff @(posedge uclk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      nlat_q     <= MIN_RATIO;
      startAck_q <= 1'b0;
      stopAck_q  <= 1'b0;
      clkEn_q    <= 1'b0;
      clkLvl_q   <= 1'b0;
      running_q  <= 1'b0;
      edgeCnt_q  <= '0;
      ratioErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      nlat_q     <= nlat_d;
      startAck_q <= startAck_d;
      stopAck_q  <= stopAck_d;
      clkEn_q    <= clkEn_d;
      clkLvl_q   <= clkLvl_d;
      running_q  <= running_d;
      edgeCnt_q  <= edgeCnt_d;
      ratioErr_q <= ratioErr_d;
    end
  end

  assign start_ack = startAck_q;
  assign stop_ack  = stopAck_q;
  assign clk_en    = clkEn_q;
  assign clk_lvl   = clkLvl_q;
  assign running   = running_q;
  assign edge_cnt  = edgeCnt_q;
  assign ratio_err = ratioErr_q;

endmodule

// File: tb/tb_ixc_uclk_div_gate.sv
// Testbench for ixc_uclk_div_gate.
// The bench instantiates the block with a 4-bit edge counter so that the
// counter wrap is reachable in a short run.
// Expected values come from two independent sources:
//   - a hand-written vector table;
//   - a period/position reference model for the randomized and corner-case
//     sequences.

module tb_ixc_uclk_div_gate;

  localparam int DIV_W = 8;
  localparam int CNT_W = 4;

  logic             uclk;
  logic             rst_n;
  logic [DIV_W-1:0] div_ratio;
  logic             start_req;
  logic             stop_req;
  logic             start_ack;
  logic             stop_ack;
  logic             clk_en;
  logic             clk_lvl;
  logic             running;
  logic [CNT_W-1:0] edge_cnt;
  logic             ratio_err;

  int checks = 0;
  int errors = 0;

  ixc_uclk_div_gate #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .uclk      (uclk),
    .rst_n     (rst_n),
    .div_ratio (div_ratio),
    .start_req (start_req),
    .start_ack (start_ack),
    .stop_req  (stop_req),
    .stop_ack  (stop_ack),
    .clk_en    (clk_en),
    .clk_lvl   (clk_lvl),
    .running   (running),
    .edge_cnt  (edge_cnt),
    .ratio_err (ratio_err)
  );

  initial uclk = 1'b0;
  always #5 uclk = ~uclk;

  // Reference model state.
  //   mMode: 0 = stopped, 1 = generating, 2 = finishing after a stop.
  //   mPos : position inside the current period.
  //   mPer : length of the current period.
  int mMode = 0;
  int mPos  = 0;
  int mPer  = 2;
  int mCnt  = 0;
  bit mErr  = 0;
  bit mSa   = 0;
  bit mSo   = 0;
  bit mEn   = 0;
  bit mRun  = 0;
  bit mLvl  = 0;

  // Advances the model by one uclk edge, using the inputs sampled at that
  // edge.
  task automatic modelStep(input bit r, input int d, input bit s, input bit p);
    int load;
    load = (d < 2) ? 2 : d;
    mSa = 0;
    mSo = 0;
    mEn = 0;
    if (!r) begin
      mMode = 0; mPos = 0; mPer = 2; mErr = 0; mCnt = 0;
    end else if (mMode == 0) begin
      if (s) begin
        mMode = 1; mPos = 0; mPer = load; mErr = mErr | (d < 2);
        mSa = 1; mEn = 1;
      end
    end else if (mPos == mPer - 1) begin
      if (mMode == 1 && !p) begin
        mPos = 0; mPer = load; mErr = mErr | (d < 2); mEn = 1;
      end else begin
        mMode = 0; mPos = 0; mSo = 1;
      end
    end else begin
      mPos = mPos + 1;
      if (mMode == 1 && p) mMode = 2;
    end
    mRun = (mMode != 0);
    mLvl = mRun && (2 * mPos < mPer);
    if (mEn) mCnt = (mCnt + 1) % (1 << CNT_W);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compares every DUT output with the reference model.
  task automatic checkOutput(input string tag);
    chk({tag, ".start_ack"}, 32'(start_ack), 32'(mSa));
    chk({tag, ".stop_ack"},  32'(stop_ack),  32'(mSo));
    chk({tag, ".clk_en"},    32'(clk_en),    32'(mEn));
    chk({tag, ".clk_lvl"},   32'(clk_lvl),   32'(mLvl));
    chk({tag, ".running"},   32'(running),   32'(mRun));
    chk({tag, ".edge_cnt"},  32'(edge_cnt),  32'(mCnt));
    chk({tag, ".ratio_err"}, 32'(ratio_err), 32'(mErr));
  endtask

  // Drives one cycle of inputs, advances past the edge and checks the
  // outputs against the model.
  task automatic applyStimulus(input bit r, input int d, input bit s, input bit p,
                               input string tag);
    rst_n     = r;
    div_ratio = DIV_W'(d);
    start_req = s;
    stop_req  = p;
    @(posedge uclk);
    modelStep(r, d, s, p);
    #1;
    checkOutput(tag);
  endtask

  // Steps at a fixed ratio until the next clk_en. A bounded wait that
  // expires counts as a failed comparison.
  task automatic waitEdge(input int d, input string tag, output int gap);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, d, 0, 0, tag);
      gap++;
      if (clk_en) return;
    end
    chk({tag, ".timeout"}, 32'd1, 32'd0);
  endtask

  typedef struct {
    bit rst;
    int div;
    bit st;
    bit sp;
    bit eSa;
    bit eSo;
    bit eEn;
    bit eLvl;
    bit eRun;
    int eCnt;
    bit eErr;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mkVec(bit r, int d, bit s, bit p, bit sa, bit so,
                                 bit en, bit lvl, bit run, int cnt, bit err);
    vec_t v;
    v.rst = r;  v.div = d;   v.st = s;     v.sp = p;
    v.eSa = sa; v.eSo = so;  v.eEn = en;   v.eLvl = lvl;
    v.eRun = run; v.eCnt = cnt; v.eErr = err;
    return v;
  endfunction

  initial begin
    int gap;
    int edges;
    int curDiv;
    string tag;

    rst_n = 1'b0; div_ratio = '0; start_req = 1'b0; stop_req = 1'b0;

    //                rst div st sp  sa so en lvl run cnt err
    vecs[0]  = mkVec(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mkVec(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mkVec(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mkVec(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mkVec(1, 4, 1, 0,  1, 0, 1, 1, 1, 1, 0);
    vecs[5]  = mkVec(1, 4, 0, 0,  0, 0, 0, 1, 1, 1, 0);
    vecs[6]  = mkVec(1, 4, 0, 0,  0, 0, 0, 0, 1, 1, 0);
    vecs[7]  = mkVec(1, 4, 0, 0,  0, 0, 0, 0, 1, 1, 0);
    vecs[8]  = mkVec(1, 4, 0, 0,  0, 0, 1, 1, 1, 2, 0);
    vecs[9]  = mkVec(1, 4, 0, 0,  0, 0, 0, 1, 1, 2, 0);
    vecs[10] = mkVec(1, 4, 0, 1,  0, 0, 0, 0, 1, 2, 0);
    vecs[11] = mkVec(1, 4, 0, 1,  0, 0, 0, 0, 1, 2, 0);
    vecs[12] = mkVec(1, 4, 0, 0,  0, 1, 0, 0, 0, 2, 0);
    vecs[13] = mkVec(1, 4, 0, 0,  0, 0, 0, 0, 0, 2, 0);
    vecs[14] = mkVec(1, 5, 1, 0,  1, 0, 1, 1, 1, 3, 0);
    vecs[15] = mkVec(1, 5, 1, 0,  0, 0, 0, 1, 1, 3, 0);
    vecs[16] = mkVec(1, 5, 1, 0,  0, 0, 0, 1, 1, 3, 0);
    vecs[17] = mkVec(1, 5, 1, 0,  0, 0, 0, 0, 1, 3, 0);
    vecs[18] = mkVec(1, 5, 1, 0,  0, 0, 0, 0, 1, 3, 0);
    vecs[19] = mkVec(1, 5, 1, 0,  0, 0, 1, 1, 1, 4, 0);
    vecs[20] = mkVec(1, 5, 1, 0,  0, 0, 0, 1, 1, 4, 0);
    vecs[21] = mkVec(1, 5, 1, 0,  0, 0, 0, 1, 1, 4, 0);
    vecs[22] = mkVec(1, 5, 1, 0,  0, 0, 0, 0, 1, 4, 0);
    vecs[23] = mkVec(1, 5, 1, 0,  0, 0, 0, 0, 1, 4, 0);
    vecs[24] = mkVec(1, 5, 1, 1,  0, 1, 0, 0, 0, 4, 0);
    vecs[25] = mkVec(1, 5, 1, 0,  1, 0, 1, 1, 1, 5, 0);
    vecs[26] = mkVec(1, 5, 0, 0,  0, 0, 0, 1, 1, 5, 0);

    // Hand-written table: reset, divide by 4 with a stop from phase 1,
    // divide by 5, a stop on the last phase, and a held-start restart.
    for (int i = 0; i < 27; i++) begin
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].rst, vecs[i].div, vecs[i].st, vecs[i].sp, {tag, ".model"});
      chk({tag, ".start_ack"}, 32'(start_ack), 32'(vecs[i].eSa));
      chk({tag, ".stop_ack"},  32'(stop_ack),  32'(vecs[i].eSo));
      chk({tag, ".clk_en"},    32'(clk_en),    32'(vecs[i].eEn));
      chk({tag, ".clk_lvl"},   32'(clk_lvl),   32'(vecs[i].eLvl));
      chk({tag, ".running"},   32'(running),   32'(vecs[i].eRun));
      chk({tag, ".edge_cnt"},  32'(edge_cnt),  32'(vecs[i].eCnt));
      chk({tag, ".ratio_err"}, 32'(ratio_err), 32'(vecs[i].eErr));
    end

    // Randomized traffic checked against the model.
    applyStimulus(0, 0, 0, 0, "rnd.reset");
    curDiv = 4;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) curDiv = $urandom_range(0, 9);
      applyStimulus($urandom_range(0, 63) != 0, curDiv,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, "rnd");
    end

    // Illegal ratio: the period becomes 2 and the error flag is sticky.
    applyStimulus(0, 0, 0, 0, "ill.reset");
    applyStimulus(1, 0, 1, 0, "ill.start");
    chk("ill.ratio_err", 32'(ratio_err), 32'd1);
    edges = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 0, 0, "ill.run");
      if (clk_en) edges++;
    end
    chk("ill.edges_in_6", 32'(edges), 32'd3);
    gap = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 3, 0, 1, "ill.stop");
      if (stop_ack) break;
      gap++;
    end
    chk("ill.stop_ack_seen", 32'(stop_ack), 32'd1);
    applyStimulus(1, 3, 1, 0, "ill.restart");
    chk("ill.err_sticky", 32'(ratio_err), 32'd1);

    // Mid-period ratio change: the change is applied only at the next wrap.
    applyStimulus(0, 4, 0, 0, "chg.reset");
    applyStimulus(1, 4, 1, 0, "chg.start");
    applyStimulus(1, 4, 0, 0, "chg.p1");
    waitEdge(6, "chg.old", gap);
    chk("chg.old_period", 32'(gap + 1), 32'd4);
    waitEdge(6, "chg.new", gap);
    chk("chg.new_period", 32'(gap), 32'd6);

    // Reset during DRAIN: everything clears and no stop_ack is produced.
    applyStimulus(0, 8, 0, 0, "rdr.reset");
    applyStimulus(1, 8, 1, 0, "rdr.start");
    applyStimulus(1, 8, 0, 0, "rdr.p1");
    applyStimulus(1, 8, 0, 1, "rdr.stop");
    applyStimulus(1, 8, 0, 0, "rdr.drain");
    chk("rdr.running_drain", 32'(running), 32'd1);
    applyStimulus(0, 8, 0, 0, "rdr.rst");
    chk("rdr.stop_ack", 32'(stop_ack), 32'd0);
    chk("rdr.running",  32'(running),  32'd0);
    chk("rdr.edge_cnt", 32'(edge_cnt), 32'd0);

    // Counter wrap: 16 edges bring the 4-bit counter back to 0.
    applyStimulus(1, 2, 1, 0, "wrap.start");
    edges = 1;
    for (int i = 0; i < 60 && edges < 16; i++) begin
      applyStimulus(1, 2, 0, 0, "wrap.run");
      if (clk_en) edges++;
    end
    chk("wrap.edges", 32'(edges), 32'd16);
    chk("wrap.edge_cnt", 32'(edge_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ixc_uclk_div_gate.md
Name: ixc_uclk_div_gate

Overview:
- Consumer side of the emulator user-clock source. Takes the free-running uclk and derives a gated, integer-divided design clock from it.
- Outputs are a clock-enable pulse and a level, controlled by a start/stop request/acknowledge handshake.
- Sits between the uclk generator and downstream design-clock domains.
- Stops always land on a period boundary, so no truncated (glitch) period is ever emitted.

Parameters:
- DIV_W, 8, width of the divide-ratio input.
- CNT_W, 16, width of the rising-edge counter.

Ports:
- uclk  input  1  emulator user clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- div_ratio  input  DIV_W  requested period N, in uclk cycles.
- start_req  input  1  level request to begin generating.
- start_ack  output  1  one-cycle pulse: generation started.
- stop_req  input  1  level request to stop at the next period end.
- stop_ack  output  1  one-cycle pulse: generation stopped.
- clk_en  output  1  one-cycle pulse at each derived rising edge.
- clk_lvl  output  1  derived clock level.
- running  output  1  high in RUN and DRAIN.
- edge_cnt  output  CNT_W  count of clk_en pulses.
- ratio_err  output  1  sticky flag: an illegal ratio (N<2) was latched.

Behaviour:
- All outputs are registered.
- Reset: when rst_n is sampled low, at the next edge:
  - state=IDLE, phase=0, Nlat=2;
  - every output is 0, including edge_cnt and ratio_err.
  - Applies mid-RUN or mid-DRAIN with no stop_ack.
- States: IDLE, RUN, DRAIN.
- Ratio latch:
  - Nlat is loaded from div_ratio on start and on every phase wrap to 0.
  - div_ratio<2 loads Nlat=2 and sets ratio_err; ratio_err is cleared only by reset.
  - A div_ratio change mid-period takes effect only at the next wrap.
- IDLE:
  - start_req sampled high in cycle t gives, in cycle t+1: state=RUN, phase=0, start_ack=1 (one cycle), running=1, clk_en=1, clk_lvl=1.
  - stop_req is ignored in IDLE; if start_req and stop_req are both high, start proceeds.
- RUN:
  - phase increments each cycle and wraps to 0 after Nlat-1.
  - clk_en=1 exactly in cycles where phase==0.
  - clk_lvl=1 when phase < (Nlat+1)>>1, so an odd N gives the extra cycle to the high phase.
  - start_req is ignored.
  - stop_req sampled high moves to DRAIN.
- DRAIN:
  - Counting continues with no new clk_en; the period in progress completes.
  - Transitions to IDLE on the cycle after phase==Nlat-1.
  - If stop_req is sampled when phase==Nlat-1, the block enters IDLE directly on the next cycle. No clk_en is emitted for the wrap that would have occurred.
  - start_req is ignored in DRAIN.
- Stop completion, first IDLE cycle: stop_ack=1 (one cycle), running=0, clk_lvl=0, clk_en=0.
- After a stop, IDLE lasts at least one cycle. A start_req held high restarts generation on the following cycle.
- edge_cnt increments on each clk_en and wraps modulo 2^CNT_W. Stop/start do not clear it; only reset does.
- Latency: start → first edge 1 cycle; stop → stop_ack ≤ Nlat cycles after stop_req is sampled.

Test Plan:
- Reset:
  - Stimulus: rst_n low 3 cycles, then high, with no requests.
  - Required: all outputs 0, state IDLE, edge_cnt=0.
- Divide by 4:
  - Stimulus: div_ratio=4, start_req at cycle 10.
  - Required: start_ack at 11; clk_en at 11, 15, 19; clk_lvl pattern 1,1,0,0 repeating; edge_cnt=3 at cycle 20.
- Divide by 5:
  - Stimulus: div_ratio=5, start.
  - Required: clk_lvl high 3 cycles, low 2 cycles; clk_en every 5 cycles.
- Stop mid-period:
  - Stimulus: div_ratio=4, stop_req at phase 1.
  - Required: DRAIN through phase 3; stop_ack and running=0 on the next cycle; no extra clk_en; edge_cnt frozen.
- Illegal ratio and mid-period change:
  - Stimulus: div_ratio=0, start.
  - Required: period 2, ratio_err=1 and still set after stop/start.
  - Stimulus: change div_ratio to 6 at phase 1.
  - Required: new period begins only at the next wrap.
- Reset mid-DRAIN and counter wrap:
  - Stimulus: rst_n low during DRAIN.
  - Required: all outputs 0 next cycle, no stop_ack.
  - Stimulus: with CNT_W=4, generate 16 edges.
  - Required: edge_cnt wraps to 0.
